countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Seconds-resolution down-counter; the decrementing counterpart to the free-running up-counting seconds timer.
- Software/FSM logic loads a duration in seconds, starts it, and may pause or cancel it. The block pulses an expiry event when the count reaches zero.
- Sits beside the up-timer in the control datapath and drives game/round timeouts and watchdog-style deadlines.

Parameters:
- TIMER_WIDTH, 16, width of the seconds count and load value.
- CLK_FREQ, 100_000_000, clk cycles per one-second tick; legal range 1 .. 2^32-1.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle request: load i_load_value and begin counting.
- i_load_value  input  TIMER_WIDTH  duration in seconds, sampled only on i_start.
- i_pause  input  1  level; while high, counting is frozen.
- i_cancel  input  1  single-cycle request: abort and return to idle.
- o_remaining  output  TIMER_WIDTH  seconds left.
- o_busy  output  1  high in RUNNING or PAUSED.
- o_expired  output  1  one-cycle pulse when the count reaches zero.
- o_done  output  1  sticky level, high in EXPIRED.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, o_remaining=0, prescaler=0.
  - o_busy=0, o_expired=0, o_done=0.
- Single clock domain, async assert; all outputs registered.
- States:
  - IDLE, RUNNING, PAUSED, EXPIRED.
  - o_busy = RUNNING|PAUSED; o_done = EXPIRED.
- Prescaler:
  - 32-bit, counts 0..CLK_FREQ-1, advancing only in RUNNING.
  - At CLK_FREQ-1 it wraps to 0 and generates an internal tick.
  - Exactly CLK_FREQ RUNNING cycles per tick.
  - Cleared on start/cancel; held in PAUSED.
- Priority per cycle: i_cancel > i_start > i_pause > tick.
- i_cancel (any state):
  - next state IDLE, o_remaining=0, prescaler=0, no expiry pulse.
- i_start (any state, no cancel):
  - load o_remaining=i_load_value, prescaler=0.
  - Next state RUNNING; if i_load_value==0, next state EXPIRED with o_expired pulsed that cycle.
  - Restart while RUNNING/PAUSED discards the old count; restart from EXPIRED is allowed.
- Start latency: o_busy and o_remaining valid on the cycle after the i_start edge.
  - First decrement lands exactly CLK_FREQ RUNNING cycles after start.
- RUNNING:
  - i_pause=1 -> PAUSED; that cycle's prescaler increment is suppressed.
  - On tick with o_remaining>1: decrement.
  - On tick with o_remaining==1: o_remaining=0, state EXPIRED, o_expired=1 for exactly one cycle, coincident with o_remaining becoming 0.
- PAUSED:
  - i_pause=0 -> RUNNING; the prescaler resumes from its held value, so no tick is lost or added.
- Pause behaviour in other states: i_pause is ignored in IDLE and EXPIRED; i_pause high at i_start still enters RUNNING, then PAUSED next cycle.
- EXPIRED holds o_remaining=0 and o_done=1 until i_start or i_cancel.
- o_remaining never wraps below 0; the decrement is only performed when the value is >=1.
- CLK_FREQ==1: a tick occurs every RUNNING cycle.

Test Plan:
- CLK_FREQ=4, reset then start with load=3 -> o_busy=1 next cycle.
  - o_remaining 3→2→1→0 at 4, 8, 12 cycles after start.
  - o_expired a single pulse at cycle 12; o_done=1 and o_busy=0 thereafter.
- CLK_FREQ=4, load=2, assert i_pause for 10 cycles starting 2 cycles after start -> first decrement at cycle 14 instead of 4; expiry at cycle 18.
- CLK_FREQ=4, load=5, i_cancel at cycle 6 -> o_remaining=0, o_busy=0, o_done=0, no o_expired pulse ever.
- Same-cycle i_start(load=7) and i_cancel -> IDLE. Later i_start(load=0) -> immediate EXPIRED with a one-cycle o_expired, o_remaining=0.
- CLK_FREQ=4, load=3, restart with load=9 at cycle 6 -> o_remaining=9 next cycle.
  - Next decrement 4 cycles after the restart; no expiry from the old count.
- Assert rst_n=0 mid-RUNNING asynchronously (between clock edges) -> all outputs 0 immediately. After release, the block stays IDLE until a new i_start.

Source files
------------

// File: rtl/countdown_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : Seconds-resolution down-counter with pause, cancel and expiry pulse
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned CLK_FREQ    = 100_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [TIMER_WIDTH-1:0] i_load_value,
    input  logic                   i_pause,
    input  logic                   i_cancel,
    output logic [TIMER_WIDTH-1:0] o_remaining,
    output logic                   o_busy,
    output logic                   o_expired,
    output logic                   o_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    localparam logic [31:0]            C_PRESC_LAST = 32'(CLK_FREQ - 1);
    localparam logic [TIMER_WIDTH-1:0] C_ONE        = TIMER_WIDTH'(1);

    state_t                 state_q,     state_d;
    logic [TIMER_WIDTH-1:0] remaining_q, remaining_d;
    logic [31:0]            presc_q,     presc_d;
    logic                   expired_q,   expired_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        expired_d   = 1'b0;

        if (i_cancel) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            presc_d     = '0;
        end else if (i_start) begin
            remaining_d = i_load_value;
            presc_d     = '0;
            if (i_load_value == '0) begin
                state_d   = S_EXPIRED;
                expired_d = 1'b1;
            end else begin
                state_d   = S_RUNNING;
            end
        end else if (state_q == S_RUNNING || state_q == S_PAUSED) begin
            if (i_pause) begin
                state_d = S_PAUSED;
            end else begin
                // The resume cycle counts, so a pause of N cycles delays the next tick by exactly N.
                state_d = S_RUNNING;
                if (presc_q == C_PRESC_LAST) begin
                    presc_d = '0;
                    if (remaining_q > C_ONE) begin
                        remaining_d = remaining_q - C_ONE;
                    end else begin
                        remaining_d = '0;
                        state_d     = S_EXPIRED;
                        expired_d   = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end
        end

        busy_d = (state_d == S_RUNNING) || (state_d == S_PAUSED);
        done_d = (state_d == S_EXPIRED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            presc_q     <= '0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_remaining = remaining_q;
    assign o_busy      = busy_q;
    assign o_expired   = expired_q;
    assign o_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for countdown_timer (CLK_FREQ=4): per-scenario tasks with a queue of
// expected {remaining, busy, expired, done} snapshots, one per clock edge.
module tb_countdown_timer;

    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_start = 1'b0;
    logic [TW-1:0] i_load_value = '0;
    logic          i_pause = 1'b0;
    logic          i_cancel = 1'b0;
    logic [TW-1:0] o_remaining;
    logic          o_busy;
    logic          o_expired;
    logic          o_done;
    logic [TW+2:0] obs;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string         name;
        int            k;
        logic [TW+2:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    countdown_timer #(.TIMER_WIDTH(TW), .CLK_FREQ(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_load_value (i_load_value),
        .i_pause      (i_pause),
        .i_cancel     (i_cancel),
        .o_remaining  (o_remaining),
        .o_busy       (o_busy),
        .o_expired    (o_expired),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    assign obs = {o_remaining, o_busy, o_expired, o_done};

    function automatic void push(string n, int k, int rem, bit b, bit x, bit d);
        exp_t t;
        t.name = n;
        t.k    = k;
        t.v    = {16'(rem), b, x, d};
        sb.push_back(t);
    endfunction

    task automatic test_reset();
        for (int k = 0; k <= 3; k++) push("reset", k, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            i_start      = (k < 3);
            i_load_value = 16'd5;
            rst_n        = (k == 3);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
        i_start = 1'b0;
    endtask

    task automatic test_basic();
        for (int k = 0; k <= 16; k++)
            push("basic", k, (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0,
                 k < 12, k == 12, k >= 12);
        for (int k = 0; k <= 16; k++) begin
            i_start      = (k == 0);
            i_load_value = 16'd3;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
    endtask

    task automatic test_pause();
        for (int k = 0; k <= 20; k++)
            push("pause", k, (k < 14) ? 2 : (k < 18) ? 1 : 0,
                 k < 18, k == 18, k >= 18);
        for (int k = 0; k <= 20; k++) begin
            i_start      = (k == 0);
            i_load_value = 16'd2;
            i_pause      = (k >= 2 && k <= 11);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
    endtask

    task automatic test_cancel();
        for (int k = 0; k <= 15; k++)
            push("cancel", k, (k < 4) ? 5 : (k < 6) ? 4 : 0, k < 6, 0, 0);
        for (int k = 0; k <= 15; k++) begin
            i_start      = (k == 0);
            i_load_value = 16'd5;
            i_cancel     = (k == 6);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
    endtask

    task automatic test_start_cancel();
        for (int k = 0; k <= 6; k++)
            push("start_cancel", k, 0, 0, k == 3, k >= 3);
        for (int k = 0; k <= 6; k++) begin
            i_start      = (k == 0 || k == 3);
            i_cancel     = (k == 0);
            i_load_value = (k == 0) ? 16'd7 : 16'd0;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
    endtask

    task automatic test_restart();
        for (int k = 0; k <= 14; k++)
            push("restart", k, (k < 4) ? 3 : (k < 6) ? 2 : (k < 10) ? 9 : (k < 14) ? 8 : 7,
                 1, 0, 0);
        for (int k = 0; k <= 14; k++) begin
            i_start      = (k == 0 || k == 6);
            i_load_value = (k == 6) ? 16'd9 : 16'd3;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
    endtask

    // load=1 with pause at start, one paused cycle, then a zero-load restart from EXPIRED
    task automatic test_back_to_back();
        for (int k = 0; k <= 8; k++)
            push("back_to_back", k, (k < 5) ? 1 : 0, k < 5, k == 5 || k == 7, k >= 5);
        for (int k = 0; k <= 8; k++) begin
            i_start      = (k == 0 || k == 7);
            i_load_value = (k == 0) ? 16'd1 : 16'd0;
            i_pause      = (k <= 1);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
        i_pause = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k <= 5; k++)
            push("async_run", k, (k < 4) ? 3 : 2, 1, 0, 0);
        push("async_assert", 5, 0, 0, 0, 0);
        for (int k = 6; k <= 10; k++) push("async_after", k, 0, 0, 0, 0);
        for (int k = 0; k <= 5; k++) begin
            i_start      = (k == 0);
            i_load_value = 16'd3;
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
            failures++;
            $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
        end
        for (int k = 6; k <= 10; k++) begin
            @(posedge clk); #1;
            rst_n = 1'b1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s k=%0d got=%h want=%h", e.name, e.k, obs, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_cancel();
        test_start_cancel();
        test_restart();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
